stream_demux1_4: RTL and testbench
==================================

# stream_demux1_4

- Registered 1-to-4 stream demultiplexer: the distribution counterpart of the team's 4:1 select mux.
- Accepts a packetised word stream on a single valid/ready input and routes each packet, whole, to one of four output channels.
- Each output channel has a one-entry holding register.
- Sits between a single producer and four consumer lanes; the destination is latched at packet start and held until the last beat.

## Interface
- W, default 8: data width of input and of each output lane.
- CLK  input  1  rising-edge clock.
- RST  input  1  synchronous, active-high reset.
- IN  input  W  input data word.
- IN_VALID  input  1  input word present.
- IN_LAST  input  1  current input word is the final beat of its packet.
- IN_READY  output  1  demux can accept the input word this cycle.
- SL  input  2  destination channel select; used only at packet start.
- OUT  output  4*W  lane k data at OUT[k*W +: W], registered.
- OUT_VALID  output  4  per-lane data valid, registered.
- OUT_LAST  output  4  per-lane last-beat flag, registered.
- OUT_READY  input  4  per-lane consumer ready.
- BUSY  output  1  high while a packet is in progress (state BURST).

## Operation
- State machine with two states: IDLE and BURST.
- Target channel T:
  - In IDLE, T = SL, sampled live.
  - In BURST, T = the locked select LK; SL is ignored.
- IN_READY = !RST & (!OUT_VALID[T] | OUT_READY[T]). It is combinational from OUT_READY and is allowed to depend on it.
- Accept = IN_VALID & IN_READY. On accept:
  - OUT lane T ← IN.
  - OUT_LAST[T] ← IN_LAST.
  - OUT_VALID[T] ← 1.
- Drain: when OUT_VALID[k] & OUT_READY[k] and lane k is not loaded this cycle, OUT_VALID[k] ← 0. OUT and OUT_LAST hold their values.
- Simultaneous drain and load on the same lane: the lane stays valid with the new word. No bubble, no loss.
- Lanes other than T are unaffected by an accept. They drain independently.
- State transitions:
  - IDLE, accept with IN_LAST=0 → BURST, LK ← SL.
  - IDLE, accept with IN_LAST=1 → stay IDLE (single-beat packet).
  - BURST, accept with IN_LAST=1 → IDLE.
  - BURST, any other cycle → stay BURST.
- Input words are never reordered. Packets are never split across lanes.
- Reset values: OUT=0, OUT_VALID=0, OUT_LAST=0, state IDLE, LK=0, BUSY=0, IN_READY=0.
- Reset mid-packet: all lane contents are discarded. The next accepted beat after reset is treated as a packet start.

## Timing
- Latency: an input accepted at edge n appears on OUT lane T with OUT_VALID[T]=1 after edge n. That is one cycle of latency.
- Throughput: one word per cycle into a lane whose consumer holds OUT_READY=1.
- A stalled lane blocks only the packet currently targeting it.
- BUSY changes on the same edge as the state register.
- The SL value used for a packet is the value present in the cycle its first beat is accepted.

## Configuration
- Macro: DEMUX_RR_EN.
- Defined:
  - SL is ignored.
  - In IDLE, T = a 2-bit round-robin pointer RP, which resets to 0.
  - RP increments by 1, wrapping 3→0, on each accepted beat with IN_LAST=1.
  - Packets therefore go to lanes 0,1,2,3,0,…
- Not defined:
  - RP does not exist.
  - Destination comes from SL as described above.
- Interface ports are identical in both builds.

## Test plan
- Reset then idle → OUT_VALID=4'b0000, BUSY=0, IN_READY=0 while RST=1 and IN_READY=1 after release (all OUT_READY=0).
- Single-beat packet: SL=2, IN=8'hA5, IN_LAST=1, OUT_READY=4'b0100 → next cycle OUT[23:16]=8'hA5, OUT_VALID=4'b0100, OUT_LAST[2]=1, BUSY stays 0.
- Three-beat packet 8'h11,8'h22,8'h33 with SL=1 at first beat, SL changed to 3 mid-packet, OUT_READY=4'b1111 → all three words on lane 1 on consecutive cycles, lane 3 untouched, BUSY high for the 2nd–3rd accept cycles.
- Backpressure: lane 0 full, OUT_READY[0]=0, new word targets lane 0 → IN_READY=0 and the word is held. Raising OUT_READY[0] accepts the word in that cycle with no gap.
- RST asserted during beat 2 of a 4-beat packet → OUT_VALID=0 and BUSY=0 after the reset edge. The next beat uses the current SL as a new packet start.
- With DEMUX_RR_EN: five single-beat packets with SL held at 0 → lanes 0,1,2,3,0 in order.

Source files
------------

// File: rtl/stream_demux1_4_if.sv
// ----------------------------------------------------------------------------
// stream_demux1_4_if
// Handshake bundle for the 1-to-4 stream demultiplexer.
//   in_data/in_valid/in_last/in_ready : single producer stream
//   out_data/out_valid/out_last       : four registered consumer lanes,
//                                       lane k data at out_data[k*W +: W]
//   out_ready                         : per-lane consumer ready
// Modports: master = producer/consumer side, slave = demux.
// ----------------------------------------------------------------------------
interface stream_demux1_4_if #(
    parameter int W = 8
);
    logic [W-1:0]   in_data;
    logic           in_valid;
    logic           in_last;
    logic           in_ready;
    logic [4*W-1:0] out_data;
    logic [3:0]     out_valid;
    logic [3:0]     out_last;
    logic [3:0]     out_ready;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_last
    );
endinterface

// File: rtl/stream_demux1_4.sv
// ----------------------------------------------------------------------------
// stream_demux1_4
// Registered 1-to-4 packet demultiplexer. Each packet is routed whole to one
// lane; the destination is chosen at the first beat and locked until the last.
// Each lane has a one-entry holding register.
//
// Ports:
//   i_clk   : rising-edge clock
//   i_rst   : synchronous active-high reset
//   i_sl    : destination lane select, sampled only at packet start
//   o_busy  : high while a packet is in progress (BURST state)
//   bus     : stream_demux1_4_if.slave (input stream + four output lanes)
//
// Build option: define DEMUX_RR_EN to ignore i_sl and assign packets to
// lanes 0,1,2,3,0,... from a round-robin pointer.
// ----------------------------------------------------------------------------
module stream_demux1_4 #(
    parameter int W = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [1:0]             i_sl,
    output logic                   o_busy,
    stream_demux1_4_if.slave       bus
);

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    state_t           r_state;
    logic [1:0]       r_lk;
    logic             r_busy;
    logic [3:0][W-1:0] r_data;
    logic [3:0]       r_vld;
    logic [3:0]       r_last;

    logic [1:0]       w_start_tgt;
    logic [1:0]       w_tgt;
    logic             w_rdy;
    logic             w_acc;
    logic [3:0]       w_load;

`ifdef DEMUX_RR_EN
    logic [1:0]       r_rp;
    logic [1:0]       w_unused_sl;

    assign w_unused_sl = i_sl;
    assign w_start_tgt = r_rp;

    // Pointer advances once per completed packet, so packets rotate lanes.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_rp <= 2'd0;
        else if (w_acc && bus.in_last)
            r_rp <= r_rp + 2'd1;
    end
`else
    assign w_start_tgt = i_sl;
`endif

    assign w_tgt = (r_state == BURST) ? r_lk : w_start_tgt;

    // Lane can take a word if empty or being drained this same cycle.
    assign w_rdy = !i_rst && (!r_vld[w_tgt] || bus.out_ready[w_tgt]);
    assign w_acc = bus.in_valid && w_rdy;

    always_comb begin
        w_load = 4'b0000;
        for (int k = 0; k < 4; k++)
            w_load[k] = w_acc && (w_tgt == 2'(k));
    end

    // Lane holding registers: load wins over drain so a simultaneous
    // drain+load keeps the lane valid with the new word.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_data <= '0;
            r_vld  <= 4'b0000;
            r_last <= 4'b0000;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (w_load[k]) begin
                    r_data[k] <= bus.in_data;
                    r_last[k] <= bus.in_last;
                    r_vld[k]  <= 1'b1;
                end else if (r_vld[k] && bus.out_ready[k]) begin
                    r_vld[k]  <= 1'b0;
                end
            end
        end
    end

    // Packet FSM; busy is registered alongside the state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_lk    <= 2'd0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_acc && !bus.in_last) begin
                        r_state <= BURST;
                        r_lk    <= w_start_tgt;
                        r_busy  <= 1'b1;
                    end
                end
                BURST: begin
                    if (w_acc && bus.in_last) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = w_rdy;
    assign bus.out_data  = r_data;
    assign bus.out_valid = r_vld;
    assign bus.out_last  = r_last;
    assign o_busy        = r_busy;

endmodule

// File: tb/tb_stream_demux1_4.sv
// ----------------------------------------------------------------------------
// tb_stream_demux1_4
// Table-driven bench for stream_demux1_4 (W=8). Each row is one clock cycle:
// inputs are driven, in_ready is compared before the edge, registered
// outputs after it. A hand-written sequence covers sustained backpressure.
// ----------------------------------------------------------------------------
module tb_stream_demux1_4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] sl;
    logic       busy;

    stream_demux1_4_if #(.W(8)) bus ();

    stream_demux1_4 #(.W(8)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_sl   (sl),
        .o_busy (busy),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [1:0]  sl;
        logic        vld;
        logic [7:0]  data;
        logic        last;
        logic [3:0]  ordy;
        logic        e_rdy;
        logic [3:0]  e_ov;
        logic [3:0]  e_ol;
        logic        e_busy;
        logic [31:0] e_out;
    } vec_t;

    vec_t vq[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic add(input logic r, input logic [1:0] s, input logic v,
                       input logic [7:0] d, input logic l, input logic [3:0] o,
                       input logic er, input logic [3:0] eov,
                       input logic [3:0] eol, input logic eb,
                       input logic [31:0] eo);
        vec_t t;
        t.rst = r; t.sl = s; t.vld = v; t.data = d; t.last = l; t.ordy = o;
        t.e_rdy = er; t.e_ov = eov; t.e_ol = eol; t.e_busy = eb; t.e_out = eo;
        vq.push_back(t);
    endtask

    task automatic chk(input string name, input int row,
                       input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [1:0] s, input logic v,
                         input logic [7:0] d, input logic l, input logic [3:0] o);
        rst = r; sl = s; bus.in_valid = v; bus.in_data = d;
        bus.in_last = l; bus.out_ready = o;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        drive(1'b1, 2'd0, 1'b0, 8'h00, 1'b0, 4'b0000);

        //   rst sl  vld data  last ordy    | rdy ov      ol      busy out
`ifdef DEMUX_RR_EN
        add(1, 0, 0, 8'h00, 0, 4'b0000,   0, 4'b0000, 4'b0000, 0, 32'h00000000);
        add(0, 0, 1, 8'h01, 1, 4'b1111,   1, 4'b0001, 4'b0001, 0, 32'h00000001);
        add(0, 0, 1, 8'h02, 1, 4'b1111,   1, 4'b0010, 4'b0011, 0, 32'h00000201);
        add(0, 0, 1, 8'h03, 1, 4'b1111,   1, 4'b0100, 4'b0111, 0, 32'h00030201);
        add(0, 0, 1, 8'h04, 1, 4'b1111,   1, 4'b1000, 4'b1111, 0, 32'h04030201);
        add(0, 0, 1, 8'h05, 1, 4'b1111,   1, 4'b0001, 4'b1111, 0, 32'h04030205);
        // multi-beat packet goes to lane 1 and holds there
        add(0, 3, 1, 8'h06, 0, 4'b1111,   1, 4'b0010, 4'b1101, 1, 32'h04030605);
        add(0, 0, 1, 8'h07, 1, 4'b1111,   1, 4'b0010, 4'b1111, 0, 32'h04030705);
`else
        // reset, then idle
        add(1, 0, 0, 8'h00, 0, 4'b0000,   0, 4'b0000, 4'b0000, 0, 32'h00000000);
        add(0, 0, 0, 8'h00, 0, 4'b0000,   1, 4'b0000, 4'b0000, 0, 32'h00000000);
        // single-beat packet to lane 2, then drain
        add(0, 2, 1, 8'hA5, 1, 4'b0100,   1, 4'b0100, 4'b0100, 0, 32'h00A50000);
        add(0, 2, 0, 8'h00, 0, 4'b0100,   1, 4'b0000, 4'b0100, 0, 32'h00A50000);
        // three-beat packet locked to lane 1 while SL moves to 3
        add(0, 1, 1, 8'h11, 0, 4'b1111,   1, 4'b0010, 4'b0100, 1, 32'h00A51100);
        add(0, 3, 1, 8'h22, 0, 4'b1111,   1, 4'b0010, 4'b0100, 1, 32'h00A52200);
        add(0, 3, 1, 8'h33, 1, 4'b1111,   1, 4'b0010, 4'b0110, 0, 32'h00A53300);
        add(0, 0, 0, 8'h00, 0, 4'b1111,   1, 4'b0000, 4'b0110, 0, 32'h00A53300);
        // backpressure on lane 0, release accepts with no gap
        add(0, 0, 1, 8'h44, 1, 4'b0000,   1, 4'b0001, 4'b0111, 0, 32'h00A53344);
        add(0, 0, 1, 8'h55, 1, 4'b0000,   0, 4'b0001, 4'b0111, 0, 32'h00A53344);
        add(0, 0, 1, 8'h55, 1, 4'b0001,   1, 4'b0001, 4'b0111, 0, 32'h00A53355);
        add(0, 0, 0, 8'h00, 0, 4'b0001,   1, 4'b0000, 4'b0111, 0, 32'h00A53355);
        // stalled lane 0 does not block a packet to lane 3
        add(0, 0, 1, 8'h66, 1, 4'b0000,   1, 4'b0001, 4'b0111, 0, 32'h00A53366);
        add(0, 3, 1, 8'h77, 1, 4'b0000,   1, 4'b1001, 4'b1111, 0, 32'h77A53366);
        // reset during beat 2 of a packet, next beat is a new start
        add(0, 2, 1, 8'h81, 0, 4'b1111,   1, 4'b0100, 4'b1011, 1, 32'h77813366);
        add(1, 2, 1, 8'h82, 0, 4'b1111,   0, 4'b0000, 4'b0000, 0, 32'h00000000);
        add(0, 3, 1, 8'h83, 0, 4'b0000,   1, 4'b1000, 4'b0000, 1, 32'h83000000);
        add(0, 0, 1, 8'h84, 1, 4'b1000,   1, 4'b1000, 4'b1000, 0, 32'h84000000);
        add(0, 0, 0, 8'h00, 0, 4'b1111,   1, 4'b0000, 4'b1000, 0, 32'h84000000);
`endif

        foreach (vq[i]) begin
            drive(vq[i].rst, vq[i].sl, vq[i].vld, vq[i].data, vq[i].last, vq[i].ordy);
            #1;
            chk("in_ready", i, {31'd0, bus.in_ready}, {31'd0, vq[i].e_rdy});
            @(posedge clk);
            #1;
            chk("out_valid", i, {28'd0, bus.out_valid}, {28'd0, vq[i].e_ov});
            chk("out_last",  i, {28'd0, bus.out_last},  {28'd0, vq[i].e_ol});
            chk("busy",      i, {31'd0, busy},          {31'd0, vq[i].e_busy});
            chk("out_data",  i, bus.out_data,           vq[i].e_out);
        end

`ifndef DEMUX_RR_EN
        // Sustained stall on lane 1: word must wait, then go in the first
        // cycle ready rises.
        begin
            int waited;
            drive(1'b0, 2'd1, 1'b1, 8'h91, 1'b1, 4'b0000);
            @(posedge clk); #1;
            drive(1'b0, 2'd1, 1'b1, 8'h92, 1'b1, 4'b0000);
            for (int c = 0; c < 3; c++) begin
                #1;
                chk("stall_rdy", 100 + c, {31'd0, bus.in_ready}, 32'd0);
                @(posedge clk); #1;
                chk("stall_hold", 100 + c, {24'd0, bus.out_data[15:8]}, 32'h91);
            end
            bus.out_ready = 4'b0010;
            waited = 0;
            #1;
            while (!bus.in_ready && waited < 4) begin
                @(posedge clk); #1;
                waited++;
            end
            chk("release_gap", 110, waited, 0);
            @(posedge clk); #1;
            chk("release_data", 111, {24'd0, bus.out_data[15:8]}, 32'h92);
            chk("release_vld", 112, {28'd0, bus.out_valid}, 32'h2);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
